// File: rtl/fetch_redirect_ctrl.sv
// Pre-IF fetch engine: owns the next-fetch PC, drives the SRAM-like
// instruction port and hands one buffered instruction at a time to IF.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EXC_VEC  = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_entry,
    input  logic        eret_flush,
    input  logic [31:0] cp0_epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        fs_allowin,
    output logic        to_fs_valid,
    output logic [31:0] to_fs_pc,
    output logic [31:0] to_fs_inst,
    output logic        to_fs_adel
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    logic [31:0] nf_pc;
    logic [31:0] req_pc;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;
    logic        buf_adel;
    logic        drop;

    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] nf_pc_next;
    logic        req_aligned;

    always_comb begin
        redir    = 1'b1;
        redir_pc = br_target;
        priority case (1'b1)
            excp_entry: redir_pc = EXC_VEC;
            eret_flush: redir_pc = cp0_epc;
            br_taken:   redir_pc = br_target;
            default:    redir    = 1'b0;
        endcase
    end

    assign nf_pc_next  = redir ? redir_pc : nf_pc;
    assign req_aligned = (req_pc[1:0] == 2'b00);

    assign inst_req    = (state == REQ) && req_aligned;
    assign inst_addr   = req_pc;
    assign to_fs_valid = (state == HOLD) && !redir;
    assign to_fs_pc    = buf_pc;
    assign to_fs_inst  = buf_inst;
    assign to_fs_adel  = buf_adel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            nf_pc    <= RESET_PC;
            req_pc   <= 32'd0;
            drop     <= 1'b0;
            buf_pc   <= 32'd0;
            buf_inst <= 32'd0;
            buf_adel <= 1'b0;
        end else begin
            if (redir) nf_pc <= redir_pc;
            case (state)
                IDLE: begin
                    state  <= REQ;
                    req_pc <= nf_pc_next;
                end
                REQ: begin
                    if (!req_aligned) begin
                        if (redir) begin
                            req_pc <= redir_pc;
                        end else begin
                            state    <= HOLD;
                            buf_pc   <= req_pc;
                            buf_inst <= 32'd0;
                            buf_adel <= 1'b1;
                        end
                    end else begin
                        // request must stay stable; its response becomes stale
                        if (redir) drop <= 1'b1;
                        if (inst_addr_ok) begin
                            state <= WAIT;
                            if (!redir && !drop) nf_pc <= req_pc + 32'd4;
                        end
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        drop <= 1'b0;
                        if (drop || redir) begin
                            state  <= REQ;
                            req_pc <= nf_pc_next;
                        end else begin
                            state    <= HOLD;
                            buf_pc   <= req_pc;
                            buf_inst <= inst_rdata;
                            buf_adel <= 1'b0;
                        end
                    end else if (redir) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redir || fs_allowin) begin
                        state  <= REQ;
                        req_pc <= nf_pc_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: a memory responder, a
// directed stimulus thread and a monitor checking requests and deliveries.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_entry;
    logic        eret_flush;
    logic [31:0] cp0_epc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_allowin;
    logic        to_fs_valid;
    logic [31:0] to_fs_pc;
    logic [31:0] to_fs_inst;
    logic        to_fs_adel;

    fetch_redirect_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .excp_entry   (excp_entry),
        .eret_flush   (eret_flush),
        .cp0_epc      (cp0_epc),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .fs_allowin   (fs_allowin),
        .to_fs_valid  (to_fs_valid),
        .to_fs_pc     (to_fs_pc),
        .to_fs_inst   (to_fs_inst),
        .to_fs_adel   (to_fs_adel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } del_t;

    logic [31:0] exp_req[$];
    del_t        exp_del[$];
    int checks = 0;
    int errors = 0;
    int n_req = 0;
    int n_del = 0;
    int n_grant = 0;
    int grant_max = 0;
    int data_delay = 0;

    logic        pending = 1'b0;
    logic [31:0] pend_addr;
    int          dcnt;

    logic        prev_req = 1'b0;
    logic        prev_aok = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_allow = 1'b0;
    logic        prev_redir = 1'b0;
    logic        cur_redir;
    logic [31:0] prev_addr;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    del_t        d;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5a5aa5a5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_req.push_back(a);
        exp_del.push_back('{pc: a, inst: mem(a), adel: 1'b0});
    endtask

    task automatic wait_del(input int n);
        for (int i = 0; i < 300 && n_del < n; i++) step();
        chk("del_count", 32'(n_del), 32'(n));
    endtask

    task automatic wait_req(input int n);
        for (int i = 0; i < 300 && n_req < n; i++) step();
        chk("req_count", 32'(n_req), 32'(n));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 300 && !to_fs_valid; i++) step();
        chk("valid_wait", 32'(to_fs_valid), 32'd1);
    endtask

    // memory responder: one outstanding request, data after dcnt cycles
    initial begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata   = 32'd0;
            if (pending) begin
                if (dcnt > 0) begin
                    dcnt--;
                end else begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = mem(pend_addr);
                    pending      = 1'b0;
                end
            end else if (inst_req && n_grant < grant_max) begin
                inst_addr_ok = 1'b1;
                n_grant++;
                pending   = 1'b1;
                pend_addr = inst_addr;
                dcnt      = data_delay;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            cur_redir = excp_entry | eret_flush | br_taken;
            if (reset) begin
                prev_req   = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_req && !prev_aok) begin
                    chk("req_stable_req", 32'(inst_req), 32'd1);
                    chk("req_stable_addr", inst_addr, prev_addr);
                end
                if (inst_req)
                    chk("req_align", 32'(inst_addr[1:0]), 32'd0);
                if (inst_req && inst_addr_ok) begin
                    n_req++;
                    if (exp_req.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL req_unexpected actual %h required none",
                                 inst_addr);
                    end else begin
                        chk("req_addr", inst_addr, exp_req.pop_front());
                    end
                end
                if (to_fs_valid)
                    chk("hold_noreq", 32'(inst_req), 32'd0);
                if (prev_valid && !prev_allow && !prev_redir && !cur_redir) begin
                    chk("hold_valid", 32'(to_fs_valid), 32'd1);
                    chk("hold_pc", to_fs_pc, prev_pc);
                    chk("hold_inst", to_fs_inst, prev_inst);
                end
                if (to_fs_valid && fs_allowin) begin
                    n_del++;
                    if (exp_del.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL del_unexpected actual %h required none",
                                 to_fs_pc);
                    end else begin
                        d = exp_del.pop_front();
                        chk("del_pc", to_fs_pc, d.pc);
                        chk("del_inst", to_fs_inst, d.inst);
                        chk("del_adel", 32'(to_fs_adel), 32'(d.adel));
                    end
                end
                prev_req   = inst_req;
                prev_aok   = inst_addr_ok;
                prev_addr  = inst_addr;
                prev_valid = to_fs_valid;
                prev_allow = fs_allowin;
                prev_pc    = to_fs_pc;
                prev_inst  = to_fs_inst;
            end
            prev_redir = cur_redir;
        end
    end

    initial begin
        reset      = 1'b1;
        excp_entry = 1'b0;
        eret_flush = 1'b0;
        cp0_epc    = 32'd0;
        br_taken   = 1'b0;
        br_target  = 32'd0;
        fs_allowin = 1'b1;
        repeat (2) step();
        #2;
        chk("rst_req", 32'(inst_req), 32'd0);
        chk("rst_addr", inst_addr, 32'd0);
        chk("rst_valid", 32'(to_fs_valid), 32'd0);
        chk("rst_adel", 32'(to_fs_adel), 32'd0);
        chk("rst_pc", to_fs_pc, 32'd0);
        chk("rst_inst", to_fs_inst, 32'd0);

        // sequential fetch from the reset vector
        push_fetch(32'hbfc00000);
        push_fetch(32'hbfc00004);
        push_fetch(32'hbfc00008);
        push_fetch(32'hbfc0000c);
        grant_max = 4;
        reset = 1'b0;
        wait_del(4);

        // held request, then exception while its response is pending
        repeat (3) step();
        push_req(32'hbfc00010);
        data_delay = 3;
        grant_max  = 5;
        wait_req(5);
        excp_entry = 1'b1;
        push_fetch(32'hbfc00380);
        grant_max  = 6;
        data_delay = 0;
        step();
        excp_entry = 1'b0;
        wait_del(5);

        // exception beats ERET in the same cycle, request not yet accepted
        excp_entry = 1'b1;
        eret_flush = 1'b1;
        cp0_epc    = 32'h80001000;
        step();
        excp_entry = 1'b0;
        eret_flush = 1'b0;
        push_req(32'hbfc00384);
        push_fetch(32'hbfc00380);
        grant_max = 8;
        wait_del(6);

        // IF stalls four cycles on a buffered instruction
        fs_allowin = 1'b0;
        push_fetch(32'hbfc00384);
        grant_max = 9;
        wait_valid();
        repeat (4) step();
        fs_allowin = 1'b1;
        wait_del(7);

        // ERET to a misaligned EPC raises AdEL without a request
        fs_allowin = 1'b0;
        eret_flush = 1'b1;
        cp0_epc    = 32'h80000002;
        step();
        eret_flush = 1'b0;
        push_req(32'hbfc00388);
        exp_del.push_back('{pc: 32'h80000002, inst: 32'd0, adel: 1'b1});
        grant_max = 10;
        wait_valid();
        chk("adel_flag", 32'(to_fs_adel), 32'd1);
        chk("adel_noreq", 32'(inst_req), 32'd0);
        fs_allowin = 1'b1;
        step();
        br_taken  = 1'b1;
        br_target = 32'hfffffffc;
        step();
        br_taken = 1'b0;
        push_fetch(32'hfffffffc);
        push_fetch(32'h00000000);
        grant_max = 12;
        wait_del(10);

        // branch kills the buffered instruction
        fs_allowin = 1'b0;
        push_req(32'h00000004);
        grant_max = 13;
        wait_valid();
        br_taken   = 1'b1;
        br_target  = 32'h00001000;
        fs_allowin = 1'b1;
        #2;
        chk("redir_kill", 32'(to_fs_valid), 32'd0);
        step();
        br_taken = 1'b0;
        push_fetch(32'h00001000);
        grant_max = 14;
        wait_del(11);

        // reset mid-transaction, late response must be ignored
        push_req(32'h00001004);
        data_delay = 3;
        grant_max  = 15;
        wait_req(15);
        reset      = 1'b1;
        data_delay = 0;
        step();
        #2;
        chk("rst2_req", 32'(inst_req), 32'd0);
        chk("rst2_valid", 32'(to_fs_valid), 32'd0);
        chk("rst2_addr", inst_addr, 32'd0);
        step();
        reset = 1'b0;
        push_fetch(32'hbfc00000);
        grant_max = 16;
        wait_del(12);

        repeat (3) step();
        chk("req_q_empty", 32'(exp_req.size()), 32'd0);
        chk("del_q_empty", 32'(exp_del.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
